// File: rtl/axi_reg_bridge.sv
// axi_reg_bridge: AXI4-Lite slave that serialises CPU register accesses into
// single-cycle register bus strobes. One access in flight at a time.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*           : AXI4-Lite write address/data/response channels
//   s_ar*/s_r*                : AXI4-Lite read address/data channels
//   raddr, rd, rdata          : register bus read (rdata returned by block)
//   waddr, wr, wdata          : register bus write
module axi_reg_bridge #(
   parameter int unsigned AWIDTH = 2,
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH+1:0] s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [DWIDTH-1:0] s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [AWIDTH+1:0] s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [DWIDTH-1:0] s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic [AWIDTH-1:0] raddr,
   output logic [AWIDTH-1:0] waddr,
   output logic              rd,
   output logic              wr,
   output logic [DWIDTH-1:0] wdata,
   input  logic [DWIDTH-1:0] rdata
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RD_ISSUE = 3'd1;
   localparam logic [2:0] ST_RD_WAIT  = 3'd2;
   localparam logic [2:0] ST_RD_RESP  = 3'd3;
   localparam logic [2:0] ST_WR_ISSUE = 3'd4;
   localparam logic [2:0] ST_WR_RESP  = 3'd5;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       ar_full;
   logic       aw_full;
   logic       w_full;
   logic [3:0] w_strb;
   logic       last_wr;
   logic       wr_pend;
   logic       ar_hs;
   logic       aw_hs;
   logic       w_hs;
   logic       unused_ok;

   // Byte-offset bits carry no meaning on a word-wide register bus.
   assign unused_ok = ^{s_awaddr[1:0], s_araddr[1:0]};

   assign s_arready = !ar_full && !reset;
   assign s_awready = !aw_full && !reset;
   assign s_wready  = !w_full  && !reset;
   assign ar_hs     = s_arvalid && s_arready;
   assign aw_hs     = s_awvalid && s_awready;
   assign w_hs      = s_wvalid  && s_wready;
   assign wr_pend   = aw_full && w_full;

   // Strobes and valids decoded from state, suppressed while in reset.
   assign rd       = (state == ST_RD_ISSUE) && !reset;
   assign wr       = (state == ST_WR_ISSUE) && (w_strb == 4'hF) && !reset;
   assign s_rvalid = (state == ST_RD_RESP) && !reset;
   assign s_bvalid = (state == ST_WR_RESP) && !reset;
   assign s_rresp  = 2'b00;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; on a tie the type not served last wins.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ar_full && wr_pend) state_nxt = last_wr ? ST_RD_ISSUE : ST_WR_ISSUE;
            else if (ar_full)       state_nxt = ST_RD_ISSUE;
            else if (wr_pend)       state_nxt = ST_WR_ISSUE;
         end
         ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
         ST_RD_WAIT:  state_nxt = ST_RD_RESP;
         ST_RD_RESP:  if (s_rready) state_nxt = ST_IDLE;
         ST_WR_ISSUE: state_nxt = ST_WR_RESP;
         ST_WR_RESP:  if (s_bready) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Holding registers, response payloads and arbitration history.
   always_ff @(posedge clk) begin
      if (reset) begin
         ar_full <= 1'b0;
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         w_strb  <= 4'h0;
         raddr   <= '0;
         waddr   <= '0;
         wdata   <= '0;
         s_rdata <= '0;
         s_bresp <= 2'b00;
         last_wr <= 1'b0;
      end else begin
         if (ar_hs) begin
            ar_full <= 1'b1;
            raddr   <= s_araddr[AWIDTH+1:2];
         end else if ((state == ST_RD_RESP) && s_rready) begin
            ar_full <= 1'b0;
         end

         if (aw_hs) begin
            aw_full <= 1'b1;
            waddr   <= s_awaddr[AWIDTH+1:2];
         end else if ((state == ST_WR_RESP) && s_bready) begin
            aw_full <= 1'b0;
         end

         if (w_hs) begin
            w_full <= 1'b1;
            wdata  <= s_wdata;
            w_strb <= s_wstrb;
         end else if ((state == ST_WR_RESP) && s_bready) begin
            w_full <= 1'b0;
         end

         if (state == ST_RD_WAIT) s_rdata <= rdata;

         // Partial-strobe writes are refused rather than read-modify-written.
         if (state == ST_WR_ISSUE) s_bresp <= (w_strb == 4'hF) ? 2'b00 : 2'b10;

         if ((state == ST_IDLE) && (state_nxt == ST_WR_ISSUE)) last_wr <= 1'b1;
         if ((state == ST_IDLE) && (state_nxt == ST_RD_ISSUE)) last_wr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_reg_bridge.sv
// tb_axi_reg_bridge: directed self-checking bench for axi_reg_bridge with a
// small register-block model on the register bus side.
module tb_axi_reg_bridge;

   logic        clk;
   logic        reset;
   logic [3:0]  s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [3:0]  s_araddr;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic [1:0]  raddr;
   logic [1:0]  waddr;
   logic        rd;
   logic        wr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   int n_chk;
   int n_bad;
   int rd_cnt;
   int wr_cnt;
   int rv_cnt;
   int both_cnt;
   int seq_n;
   logic        seq_arr [0:63];
   logic [31:0] regval  [0:3];

   axi_reg_bridge #(.AWIDTH(2), .DWIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .raddr(raddr), .waddr(waddr), .rd(rd), .wr(wr), .wdata(wdata), .rdata(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register block model: registered read data, write on strobe.
   always @(posedge clk) begin
      if (rd) rdata <= regval[raddr];
      if (wr) regval[waddr] <= wdata;
   end

   // Strobe monitors.
   always @(posedge clk) begin
      if (rd) rd_cnt <= rd_cnt + 1;
      if (wr) wr_cnt <= wr_cnt + 1;
      if (s_rvalid) rv_cnt <= rv_cnt + 1;
      if (rd && wr) both_cnt <= both_cnt + 1;
      if ((rd || wr) && seq_n < 64) begin
         seq_arr[seq_n] <= wr;
         seq_n <= seq_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Present one AR; returns just after the edge that ends cycle 0.
   task automatic issue_ar(input logic [3:0] addr);
      @(posedge clk); #1;
      s_araddr = addr; s_arvalid = 1'b1;
      @(negedge clk); chk("arready_c0", 32'(s_arready), 32'd1);
      @(posedge clk); #1;
      s_arvalid = 1'b0;
   endtask

   // Cycle-accurate read check from cycle 1 up to the first response cycle.
   task automatic finish_read(input logic [1:0] ea, input logic [31:0] ed);
      @(negedge clk); chk("rd_c1", 32'(rd), 32'd0);
                      chk("arready_c1", 32'(s_arready), 32'd0);
      @(negedge clk); chk("rd_c2", 32'(rd), 32'd1);
                      chk("raddr_c2", 32'(raddr), 32'(ea));
      @(negedge clk); chk("rd_c3", 32'(rd), 32'd0);
                      chk("rvalid_c3", 32'(s_rvalid), 32'd0);
      @(negedge clk); chk("rvalid_c4", 32'(s_rvalid), 32'd1);
                      chk("rdata_c4", s_rdata, ed);
                      chk("rresp_c4", 32'(s_rresp), 32'd0);
   endtask

   // Cycle-accurate write check from cycle 1 up to the first response cycle.
   task automatic finish_write(input logic [1:0] ea, input logic [31:0] ed,
                               input logic [1:0] eresp, input logic ewr);
      @(negedge clk); chk("wr_c1", 32'(wr), 32'd0);
      @(negedge clk); chk("wr_c2", 32'(wr), 32'(ewr));
      if (ewr) begin
         chk("waddr_c2", 32'(waddr), 32'(ea));
         chk("wdata_c2", wdata, ed);
      end
      @(negedge clk); chk("bvalid_c3", 32'(s_bvalid), 32'd1);
                      chk("bresp_c3", 32'(s_bresp), 32'(eresp));
   endtask

   initial begin
      int r0, w0, v0, s0, guard;
      logic [31:0] hold;
      n_chk = 0; n_bad = 0; rd_cnt = 0; wr_cnt = 0; rv_cnt = 0; both_cnt = 0; seq_n = 0;
      regval[0] = 32'h1111_0000; regval[1] = 32'h2222_1111;
      regval[2] = 32'hDEAD_BEEF; regval[3] = 32'h0000_0000;
      rdata = 32'h0;
      reset = 1'b1;
      s_awaddr = 4'h0; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0;
      s_araddr = 4'h0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(s_arready), 32'd0);
      chk("rst_awready", 32'(s_awready), 32'd0);
      chk("rst_wready", 32'(s_wready), 32'd0);
      chk("rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_bvalid", 32'(s_bvalid), 32'd0);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("idle_arready", 32'(s_arready), 32'd1);
      chk("idle_awready", 32'(s_awready), 32'd1);
      chk("idle_wready", 32'(s_wready), 32'd1);
      chk("idle_rdata", s_rdata, 32'd0);
      chk("idle_bresp", 32'(s_bresp), 32'd0);
      chk("idle_addr", 32'({raddr, waddr}), 32'd0);
      chk("idle_wdata", wdata, 32'd0);
      chk("idle_strobes", 32'({rd, wr}), 32'd0);

      // Single read of 0x8.
      r0 = rd_cnt;
      issue_ar(4'h8);
      finish_read(2'd2, 32'hDEAD_BEEF);
      @(negedge clk); chk("rvalid_after_hs", 32'(s_rvalid), 32'd0);
      chk("rd_count_single", 32'(rd_cnt - r0), 32'd1);

      // Write with W three cycles ahead of AW.
      w0 = wr_cnt;
      @(posedge clk); #1;
      s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
      @(negedge clk); chk("wready_w", 32'(s_wready), 32'd1);
      @(posedge clk); #1; s_wvalid = 1'b0;
      repeat (3) begin
         @(negedge clk); chk("wready_held", 32'(s_wready), 32'd0);
         @(posedge clk); #1;
      end
      chk("no_wr_before_aw", 32'(wr_cnt - w0), 32'd0);
      s_awaddr = 4'hC; s_awvalid = 1'b1;
      @(negedge clk); chk("awready_aw", 32'(s_awready), 32'd1);
      @(posedge clk); #1; s_awvalid = 1'b0;
      finish_write(2'd3, 32'h1234_5678, 2'b00, 1'b1);
      @(negedge clk); chk("bvalid_after_hs", 32'(s_bvalid), 32'd0);
      chk("wr_count_full", 32'(wr_cnt - w0), 32'd1);

      // Partial strobe: refused, response held under backpressure.
      w0 = wr_cnt;
      s_bready = 1'b0;
      @(posedge clk); #1;
      s_awaddr = 4'h4; s_awvalid = 1'b1;
      s_wdata = 32'hAAAA_5555; s_wstrb = 4'h3; s_wvalid = 1'b1;
      @(posedge clk); #1; s_awvalid = 1'b0; s_wvalid = 1'b0;
      finish_write(2'd1, 32'hAAAA_5555, 2'b10, 1'b0);
      repeat (6) begin
         @(negedge clk);
         chk("bvalid_bp", 32'(s_bvalid), 32'd1);
         chk("bresp_bp", 32'(s_bresp), 32'd2);
      end
      @(posedge clk); #1; s_bready = 1'b1;
      @(negedge clk); chk("bvalid_hs_cycle", 32'(s_bvalid), 32'd1);
      @(negedge clk); chk("bvalid_released", 32'(s_bvalid), 32'd0);
      chk("wr_count_partial", 32'(wr_cnt - w0), 32'd0);
      issue_ar(4'h4);
      finish_read(2'd1, 32'h2222_1111);

      // Read backpressure on the register written above.
      @(posedge clk); #1; s_rready = 1'b0;
      r0 = rd_cnt;
      issue_ar(4'hC);
      finish_read(2'd3, 32'h1234_5678);
      hold = s_rdata;
      repeat (10) begin
         @(negedge clk);
         chk("rvalid_bp", 32'(s_rvalid), 32'd1);
         chk("rdata_bp", s_rdata, hold);
         chk("arready_bp", 32'(s_arready), 32'd0);
      end
      chk("rd_count_bp", 32'(rd_cnt - r0), 32'd1);
      @(posedge clk); #1; s_rready = 1'b1;
      @(negedge clk);
      @(negedge clk); chk("arready_after_r", 32'(s_arready), 32'd1);

      // Both pending at reset exit, continuously: W,R,W,R.
      @(posedge clk); #1; reset = 1'b1;
      s_araddr = 4'h0; s_arvalid = 1'b1;
      s_awaddr = 4'h0; s_awvalid = 1'b1;
      s_wdata = 32'h0000_0055; s_wstrb = 4'hF; s_wvalid = 1'b1;
      @(negedge clk); chk("tie_rst_arready", 32'(s_arready), 32'd0);
      @(posedge clk); #1;
      s0 = seq_n;
      reset = 1'b0;
      guard = 0;
      while (seq_n < s0 + 4 && guard < 80) begin
         @(posedge clk); #1;
         guard++;
      end
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      chk("tie_timeout", 32'(seq_n >= s0 + 4), 32'd1);
      chk("tie_seq", 32'({seq_arr[s0], seq_arr[s0+1], seq_arr[s0+2], seq_arr[s0+3]}), 32'hA);
      repeat (20) @(posedge clk);
      chk("rd_wr_never_both", 32'(both_cnt), 32'd0);

      // Reset during RD_WAIT drops the read.
      issue_ar(4'h8);
      @(posedge clk); #1;
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_rd", 32'(rd), 32'd0);
      chk("mid_rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("mid_rst_ready", 32'({s_arready, s_awready, s_wready}), 32'd0);
      @(posedge clk); #1; reset = 1'b0;
      r0 = rd_cnt; v0 = rv_cnt;
      repeat (8) @(negedge clk);
      chk("dropped_no_rvalid", 32'(rv_cnt - v0), 32'd0);
      chk("dropped_no_rd", 32'(rd_cnt - r0), 32'd0);
      chk("post_rst_arready", 32'(s_arready), 32'd1);
      issue_ar(4'h8);
      finish_read(2'd2, 32'hDEAD_BEEF);
      @(negedge clk); chk("fresh_rvalid_done", 32'(s_rvalid), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
